// File: rtl/mod_n_updown_counter_pkg.sv
// Shared constants and types for the mod-N up/down counter and the timer
// digit chains built from it.
package mod_n_updown_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // What the counter does on the coming edge, reset aside.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_INC,
    ACT_DEC,
    ACT_WRAP_LO,
    ACT_WRAP_HI,
    ACT_SAT
  } act_e;

endpackage

// File: rtl/mod_n_updown_counter_if.sv
// Control/status bundle for one counter digit; the counter is the slave,
// whoever drives its controls is the master.
interface mod_n_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap_pulse;

  modport master (
    output en, up_dn, sat_mode, load, load_val,
    input  count, tc, wrap_pulse
  );

  modport slave (
    input  en, up_dn, sat_mode, load, load_val,
    output count, tc, wrap_pulse
  );
endinterface

// File: rtl/mod_n_updown_counter.sv
// Mod-N up/down counter with clamped load, wrap/saturate modes, a
// combinational cascade carry (tc) and a registered wrap pulse.
module mod_n_updown_counter
  import mod_n_updown_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 10,
  parameter int RESET_VAL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mod_n_updown_counter_if.slave bus
);

  generate
    if (MODULUS < 2 || MODULUS > 2**WIDTH || RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_params
      $error("mod_n_updown_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);
  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_at_max;
  logic             w_at_min;
  act_e             w_act;

  assign w_at_max       = (r_count == MAX_CNT);
  assign w_at_min       = (r_count == '0);
  assign w_load_clamped = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val : MAX_CNT;

  always_comb begin
    w_act = ACT_HOLD;
    if (bus.load) begin
      w_act = ACT_LOAD;
    end else if (bus.en) begin
      if (bus.up_dn == DIR_UP) begin
        if (!w_at_max)                  w_act = ACT_INC;
        else if (bus.sat_mode == MODE_SAT) w_act = ACT_SAT;
        else                            w_act = ACT_WRAP_LO;
      end else begin
        if (!w_at_min)                  w_act = ACT_DEC;
        else if (bus.sat_mode == MODE_SAT) w_act = ACT_SAT;
        else                            w_act = ACT_WRAP_HI;
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    case (w_act)
      ACT_LOAD:    w_count_nxt = w_load_clamped;
      ACT_INC:     w_count_nxt = r_count + WIDTH'(1);
      ACT_DEC:     w_count_nxt = r_count - WIDTH'(1);
      ACT_WRAP_LO: begin
        w_count_nxt = '0;
        w_wrap_nxt  = 1'b1;
      end
      ACT_WRAP_HI: begin
        w_count_nxt = MAX_CNT;
        w_wrap_nxt  = 1'b1;
      end
      default:     w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= RST_CNT;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Carry is independent of load so a downstream digit sees it in-cycle.
  assign bus.tc = bus.en & (bus.sat_mode == MODE_WRAP) &
                  ((bus.up_dn == DIR_UP) ? w_at_max : w_at_min);

  assign bus.count      = r_count;
  assign bus.wrap_pulse = r_wrap;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench: mod-10 digit, chained mod-10 tens digit, mod-16 digit.
module tb_mod_n_updown_counter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mod_n_updown_counter_if #(.WIDTH(4)) b0();
  mod_n_updown_counter_if #(.WIDTH(4)) b1();
  mod_n_updown_counter_if #(.WIDTH(4)) b2();

  assign b1.en = b0.tc;

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_ones (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_tens (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  mod_n_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_hex (
    .clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    b0.en = 0; b0.up_dn = 0; b0.sat_mode = 0; b0.load = 0; b0.load_val = '0;
    b1.up_dn = 1; b1.sat_mode = 0; b1.load = 0; b1.load_val = '0;
    b2.en = 0; b2.up_dn = 0; b2.sat_mode = 0; b2.load = 0; b2.load_val = '0;

    // Reset state
    tick();
    chk("rst_count", b0.count, 0);
    chk("rst_wrap", b0.wrap_pulse, 0);
    chk("rst_tc", b0.tc, 0);
    rst_n = 1'b1;

    // Count up, wrap mode, 12 cycles
    b0.en = 1; b0.up_dn = 1; b0.sat_mode = 0;
    #1;
    for (int i = 0; i < 12; i++) begin
      chk("up_tc", b0.tc, ((i % 10) == 9));
      tick();
      chk("up_count", b0.count, (i + 1) % 10);
      chk("up_wrap", b0.wrap_pulse, (i == 9));
    end

    // Load 3 then count down saturating
    b0.en = 0; b0.load = 1; b0.load_val = 4'd3;
    tick();
    chk("ld3_count", b0.count, 3);
    chk("ld3_wrap", b0.wrap_pulse, 0);
    b0.load = 0; b0.en = 1; b0.up_dn = 0; b0.sat_mode = 1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("dsat_tc", b0.tc, 0);
      tick();
      chk("dsat_count", b0.count, (i < 3) ? (2 - i) : 0);
      chk("dsat_wrap", b0.wrap_pulse, 0);
    end

    // Hold with en low
    b0.en = 0;
    tick();
    chk("hold_count", b0.count, 0);

    // Load clamps above modulus
    b0.load = 1; b0.load_val = 4'd14;
    tick();
    chk("clamp_count", b0.count, 9);
    // Load beats en even at the wrap point; tc still follows its formula
    b0.load_val = 4'd2; b0.en = 1; b0.up_dn = 1; b0.sat_mode = 0;
    #1;
    chk("ldpri_tc", b0.tc, 1);
    tick();
    chk("ldpri_count", b0.count, 2);
    chk("ldpri_wrap", b0.wrap_pulse, 0);

    // Saturate up at 9
    b0.load_val = 4'd9; b0.en = 0;
    tick();
    b0.load = 0; b0.en = 1; b0.up_dn = 1; b0.sat_mode = 1;
    #1;
    chk("usat_tc", b0.tc, 0);
    tick();
    chk("usat_count", b0.count, 9);
    chk("usat_wrap", b0.wrap_pulse, 0);

    // Reset mid-count at 7 overrides load and en
    b0.en = 0; b0.load = 1; b0.load_val = 4'd7;
    tick();
    chk("pre_rst_count", b0.count, 7);
    rst_n = 0; b0.en = 1; b0.up_dn = 1; b0.sat_mode = 0; b0.load_val = 4'd5;
    tick();
    chk("mid_rst_count", b0.count, 0);
    chk("mid_rst_wrap", b0.wrap_pulse, 0);
    rst_n = 1; b0.load = 0;
    tick();
    chk("post_rst_count", b0.count, 1);

    // Reset at the wrap point suppresses the wrap pulse
    b0.en = 0; b0.load = 1; b0.load_val = 4'd9;
    tick();
    rst_n = 0; b0.load = 0; b0.en = 1;
    tick();
    chk("rst9_count", b0.count, 0);
    chk("rst9_wrap", b0.wrap_pulse, 0);

    // Two-digit chain, 25 up-counts from 00
    b0.en = 0;
    tick();
    rst_n = 1; b0.en = 1; b0.up_dn = 1; b0.sat_mode = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      chk("chain_tens", b1.count, (i + 1) / 10);
    end
    chk("chain_ones_final", b0.count, 5);
    chk("chain_tens_final", b1.count, 2);

    // Mod-16 digit: down from 0 wraps to 15
    b0.en = 0;
    b2.en = 1; b2.up_dn = 0; b2.sat_mode = 0;
    #1;
    chk("hex_tc", b2.tc, 1);
    tick();
    chk("hex_count", b2.count, 15);
    chk("hex_wrap", b2.wrap_pulse, 1);
    tick();
    chk("hex_count2", b2.count, 14);
    chk("hex_wrap2", b2.wrap_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod_n_updown_counter.md
MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits.
REQ-002 Parameter MODULUS, default 10: count range 0..MODULUS-1.
REQ-003 Parameter RESET_VAL, default 0: count value after reset.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 Port en, input, 1: count enable for one step per cycle.
REQ-007 Port up_dn, input, 1: direction; 1 = up, 0 = down.
REQ-008 Port sat_mode, input, 1: limit behaviour; 1 = saturate at limit, 0 = wrap around.
REQ-009 Port load, input, 1: synchronous parallel load strobe.
REQ-010 Port load_val, input, WIDTH: value to load.
REQ-011 Port count, output, WIDTH: current count, registered.
REQ-012 Port tc, output, 1: terminal count / cascade carry, combinational.
REQ-013 Port wrap_pulse, output, 1: registered one-cycle pulse after a wrap.

Function
REQ-014 The block SHALL apply this per-cycle priority: reset, then load, then en; with none active, count holds.
REQ-015 On load, count SHALL take load_val if load_val < MODULUS, else MODULUS-1 (clamp), irrespective of en, up_dn and sat_mode.
REQ-016 With en=1 and up_dn=1 and count < MODULUS-1, count SHALL increment by 1 next cycle.
REQ-017 With en=1 and up_dn=1 and count = MODULUS-1, count SHALL go to 0 if sat_mode=0, and SHALL hold MODULUS-1 if sat_mode=1.
REQ-018 With en=1 and up_dn=0 and count > 0, count SHALL decrement by 1 next cycle.
REQ-019 With en=1 and up_dn=0 and count = 0, count SHALL go to MODULUS-1 if sat_mode=0, and SHALL hold 0 if sat_mode=1.
REQ-020 tc SHALL equal en AND NOT sat_mode AND ((up_dn AND count=MODULUS-1) OR (NOT up_dn AND count=0)), and SHALL be usable as the en of a cascaded stage in the same cycle.
REQ-021 wrap_pulse SHALL be 1 for exactly one cycle, the cycle after a REQ-017/REQ-019 wrap transition, and 0 otherwise, including on load and saturation holds.
REQ-022 Changes to up_dn or sat_mode SHALL take effect on the same cycle's edge without pipeline delay; there is no internal state besides count and wrap_pulse.
REQ-023 All arithmetic SHALL be performed in WIDTH bits with no overflow beyond MODULUS-1; count SHALL never leave 0..MODULUS-1.
REQ-024 Elaboration SHALL fail if MODULUS < 2, MODULUS > 2**WIDTH, or RESET_VAL >= MODULUS.

Reset
REQ-025 When rst_n=0 at a rising clk edge, count SHALL become RESET_VAL and wrap_pulse SHALL become 0, overriding load and en.
REQ-026 A reset asserted mid-count SHALL take effect on the next edge, with no partial step; counting resumes on the first edge with rst_n=1.
REQ-027 tc SHALL follow REQ-020 from the reset count value, with no special reset forcing.

Structure
REQ-028 A shared package SHALL hold the direction constants (DIR_UP=1, DIR_DOWN=0) and the mode constants (MODE_WRAP=0, MODE_SAT=1) for use by the timer digit chains.
REQ-029 The block SHALL be a single module with no sub-module; multi-digit timers are built by instantiating it and chaining tc into the next stage's en.

Verification
REQ-030 Scenario (WIDTH=4, MODULUS=10): reset; en=1, up_dn=1, sat_mode=0 for 12 cycles -> count 0..9,0,1; tc=1 only while count=9; wrap_pulse=1 the cycle count=0 follows 9.
REQ-031 Scenario: load=1, load_val=3; then en=1, up_dn=0, sat_mode=1 for 6 cycles -> count 3,2,1,0,0,0; tc=0 throughout; wrap_pulse=0 throughout.
REQ-032 Scenario: load=1, load_val=14 -> count=9; with load=1, en=1 in the same cycle, load wins.
REQ-033 Scenario: two instances chained, tc0 driving en1, counting up for 25 cycles from 00 -> digits read 2,5; the tens digit steps only on ones-digit 9->0.
REQ-034 Scenario: count=7 counting up, rst_n=0 for 1 cycle with load=1 -> count=RESET_VAL=0 and wrap_pulse=0; count=1 two edges later.
REQ-035 Scenario: MODULUS=16, WIDTH=4, down from 0 with sat_mode=0 -> count=15, wrap_pulse=1 the next cycle.
